// File: rtl/blind_spot_alert_ctrl.sv
// Blind-spot warning sequencer: per-side debounce/hold FSMs, mirror LEDs,
// shared flash phase and a single non-retriggerable chime.
//
// Ports:
//   CLK, RST (async active-low)   clock and reset
//   enable                        0 synchronously idles everything
//   right_side, left_side         raw proximity sensors
//   turn_right, turn_left         turn-signal inputs
//   blind[1:0]                    registered occupancy {left, right}
//   led_right, led_left           registered mirror indicators
//   chime                         shared audible warning
module blind_spot_alert_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int FLASH_HALF      = 4,
    parameter int CHIME_CYCLES    = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       right_side,
    input  logic       left_side,
    input  logic       turn_right,
    input  logic       turn_left,
    output logic [1:0] blind,
    output logic       led_right,
    output logic       led_left,
    output logic       chime
);

    localparam int MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                          DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int FW   = $clog2(FLASH_HALF + 1);
    localparam int KW   = $clog2(CHIME_CYCLES + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [FW-1:0] FL_LAST   = FW'(FLASH_HALF - 1);
    localparam logic [KW-1:0] CH_LOAD   = KW'(CHIME_CYCLES);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_DETECT,
        S_OCC,
        S_HOLD
    } side_state_e;

    // Index 0 is the right side, index 1 the left side.
    side_state_e   st_q  [2];
    side_state_e   st_d  [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic [1:0]    sens;
    logic [1:0]    turn;
    logic [1:0]    occ;
    logic [1:0]    warn;
    logic [1:0]    req;

    logic [1:0]    blind_q, blind_d;
    logic [1:0]    led_q, led_d;
    logic [1:0]    warn_q, warn_d;
    logic [FW-1:0] fl_cnt_q, fl_cnt_d;
    logic          phase_q, phase_d;
    logic [KW-1:0] ch_cnt_q, ch_cnt_d;

    assign sens = {left_side, right_side};
    assign turn = {turn_left, turn_right};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            unique case (st_q[i])
                S_CLEAR: begin
                    if (sens[i]) begin
                        st_d[i]  = S_DETECT;
                        cnt_d[i] = CW'(1);
                    end
                end
                S_DETECT: begin
                    if (!sens[i]) begin
                        st_d[i]  = S_CLEAR;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        st_d[i]  = S_OCC;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                S_OCC: begin
                    if (!sens[i]) begin
                        st_d[i]  = S_HOLD;
                        cnt_d[i] = '0;
                    end
                end
                S_HOLD: begin
                    if (sens[i]) begin
                        st_d[i]  = S_OCC;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == HOLD_LAST) begin
                        st_d[i]  = S_CLEAR;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    st_d[i]  = S_CLEAR;
                    cnt_d[i] = '0;
                end
            endcase
            if (!enable) begin
                st_d[i]  = S_CLEAR;
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            occ[i] = (st_q[i] == S_OCC) || (st_q[i] == S_HOLD);
        end
    end

    assign warn = occ & turn;
    // Rising edge of a side's warning requests the chime.
    assign req  = warn & ~warn_q;

    // Flash phase rests at 1 so the first half-period is "on".
    always_comb begin
        fl_cnt_d = fl_cnt_q;
        phase_d  = phase_q;
        if (!enable || (warn == 2'b00)) begin
            fl_cnt_d = '0;
            phase_d  = 1'b1;
        end else if (fl_cnt_q == FL_LAST) begin
            fl_cnt_d = '0;
            phase_d  = ~phase_q;
        end else begin
            fl_cnt_d = fl_cnt_q + FW'(1);
        end
    end

    // Requests arriving while the chime runs are dropped, not queued.
    always_comb begin
        ch_cnt_d = ch_cnt_q;
        if (!enable) begin
            ch_cnt_d = '0;
        end else if (ch_cnt_q != '0) begin
            ch_cnt_d = ch_cnt_q - KW'(1);
        end else if (req != 2'b00) begin
            ch_cnt_d = CH_LOAD;
        end
    end

    always_comb begin
        blind_d = '0;
        led_d   = '0;
        warn_d  = '0;
        if (enable) begin
            blind_d = occ;
            warn_d  = warn;
            for (int i = 0; i < 2; i++) begin
                led_d[i] = warn[i] ? phase_q : occ[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= S_CLEAR;
                cnt_q[i] <= '0;
            end
            blind_q  <= '0;
            led_q    <= '0;
            warn_q   <= '0;
            fl_cnt_q <= '0;
            phase_q  <= 1'b1;
            ch_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            blind_q  <= blind_d;
            led_q    <= led_d;
            warn_q   <= warn_d;
            fl_cnt_q <= fl_cnt_d;
            phase_q  <= phase_d;
            ch_cnt_q <= ch_cnt_d;
        end
    end

    assign blind     = blind_q;
    assign led_right = led_q[0];
    assign led_left  = led_q[1];
    assign chime     = (ch_cnt_q != '0);

endmodule

// File: tb/tb_blind_spot_alert_ctrl.sv
// Directed bench for blind_spot_alert_ctrl with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_blind_spot_alert_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enable;
    logic       right_side;
    logic       left_side;
    logic       turn_right;
    logic       turn_left;
    logic [1:0] blind;
    logic       led_right;
    logic       led_left;
    logic       chime;

    int vectors = 0;
    int errs    = 0;

    blind_spot_alert_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (enable),
        .right_side (right_side),
        .left_side  (left_side),
        .turn_right (turn_right),
        .turn_left  (turn_left),
        .blind      (blind),
        .led_right  (led_right),
        .led_left   (led_left),
        .chime      (chime)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        RST        = 1'b0;
        enable     = 1'b1;
        right_side = 1'b1;
        left_side  = 1'b0;
        turn_right = 1'b0;
        turn_left  = 1'b0;

        // Reset wins over an asserted sensor.
        step(2);
        chk("rst_blind", blind, 2'b00);
        chk("rst_leds", {led_left, led_right}, 2'b00);
        chk("rst_chime", {1'b0, chime}, 2'b00);
        right_side = 1'b0;
        RST = 1'b1;
        step(2);
        chk("post_rst_blind", blind, 2'b00);

        // 3-cycle pulse is rejected by the debounce.
        right_side = 1'b1;
        step(3);
        right_side = 1'b0;
        step(4);
        chk("deb_reject", blind, 2'b00);

        // Full debounce: blind after 5 edges, not 4.
        right_side = 1'b1;
        step(4);
        chk("deb_edge4", blind, 2'b00);
        step(1);
        chk("deb_edge5", blind, 2'b01);
        chk("deb_led_r", {led_left, led_right}, 2'b01);

        // Clear latency: blind drops on edge 10 after the first low sample.
        right_side = 1'b0;
        step(9);
        chk("hold_edge9", blind, 2'b01);
        step(1);
        chk("hold_edge10", blind, 2'b00);
        chk("hold_led_off", {led_left, led_right}, 2'b00);

        // Re-assert during HOLD returns to OCCUPIED without a drop.
        right_side = 1'b1;
        step(5);
        chk("rehold_occ", blind, 2'b01);
        right_side = 1'b0;
        step(3);
        chk("rehold_in_hold", blind, 2'b01);
        right_side = 1'b1;
        step(12);
        chk("rehold_kept", blind, 2'b01);
        // Hold timer restarts from scratch after returning to OCCUPIED.
        right_side = 1'b0;
        step(9);
        chk("rehold_edge9", blind, 2'b01);
        step(1);
        chk("rehold_edge10", blind, 2'b00);

        // Left occupied, then turn_left: 6-cycle chime, 4/4 flash.
        left_side = 1'b1;
        step(5);
        chk("left_occ", blind, 2'b10);
        chk("left_led", {led_left, led_right}, 2'b10);
        turn_left = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic ce;
            logic le;
            step(1);
            ce = (k <= 6);
            le = (((k - 1) / 4) % 2) == 0;
            chk($sformatf("lchime_k%0d", k), {1'b0, chime}, {1'b0, ce});
            chk($sformatf("lflash_k%0d", k), {led_left, led_right},
                {le, 1'b0});
        end
        turn_left = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk($sformatf("lsolid_k%0d", k), {led_left, led_right}, 2'b10);
        end
        chk("lsolid_chime", {1'b0, chime}, 2'b00);

        // Both sides, simultaneous turns: one chime; re-pulse is dropped.
        right_side = 1'b1;
        step(5);
        chk("both_occ", blind, 2'b11);
        turn_left  = 1'b1;
        turn_right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk($sformatf("bchime_k%0d", k), {1'b0, chime},
                {1'b0, (k <= 6) ? 1'b1 : 1'b0});
            if (k == 1) turn_right = 1'b0;
            if (k == 2) turn_right = 1'b1;
        end

        // enable=0 mid-chime clears everything on the next edge only.
        turn_left  = 1'b0;
        turn_right = 1'b0;
        step(2);
        turn_left = 1'b1;
        step(2);
        chk("en_chime_on", {1'b0, chime}, 2'b01);
        enable = 1'b0;
        #1;
        chk("en_before_edge", blind, 2'b11);
        step(1);
        chk("en_blind", blind, 2'b00);
        chk("en_leds", {led_left, led_right}, 2'b00);
        chk("en_chime", {1'b0, chime}, 2'b00);
        enable = 1'b1;
        step(4);
        chk("en_redeb4", blind, 2'b00);
        step(1);
        chk("en_redeb5", blind, 2'b11);
        chk("en_rechime", {1'b0, chime}, 2'b01);

        // Async reset mid-debounce of the left side.
        turn_left  = 1'b0;
        left_side  = 1'b0;
        right_side = 1'b0;
        step(12);
        chk("pre_rst_clear", blind, 2'b00);
        right_side = 1'b1;
        step(5);
        chk("pre_rst_r", blind, 2'b01);
        left_side = 1'b1;
        step(2);
        RST = 1'b0;
        #2;
        chk("arst_blind", blind, 2'b00);
        chk("arst_leds", {led_left, led_right}, 2'b00);
        #2;
        RST = 1'b1;
        step(4);
        chk("arst_redeb4", blind, 2'b00);
        step(1);
        chk("arst_redeb5", blind, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
